// File: rtl/wir_shift_sequencer.sv
// wir_shift_sequencer
//   Loads an instruction into a serial Wrapper Instruction Register (WIR). The accepted
//   opcode is shifted out LSB first (instr[1] first) while the old WIR contents are shifted
//   back in on wir_so and reported on prev_instr. Every output is registered: each is
//   computed from next-state values so it is valid for the whole state it belongs to.
//
//   Optional feature: define WIR_CAPTURE_EN to insert a one-cycle CAPTURE state before
//   SHIFT. The WIR then captures first, so prev_instr shows the captured value. Without
//   it, CAPTURE is never entered and wir_capture is tied low.
//
// Ports
//   CLK          in   sole clock, rising edge
//   resetn       in   synchronous active-low reset
//   start        in   load request, only sampled in IDLE
//   abort        in   cancels a load in CAPTURE or SHIFT
//   instr        in   [SIZE:1] opcode, captured on the accepted start
//   wir_so       in   WIR serial out (readback)
//   wir_si       out  WIR serial in
//   wir_shift    out  WIR shift strobe
//   wir_capture  out  WIR capture strobe
//   wir_update   out  WIR update strobe
//   WRSTN        out  WIR reset, active-low, low for one cycle after a reset edge
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse when a load completes
//   prev_instr   out  [SIZE:1] WIR contents shifted out by the last completed load
module wir_shift_sequencer #(
  parameter int unsigned SIZE = 12
) (
  input  logic          CLK,
  input  logic          resetn,
  input  logic          start,
  input  logic          abort,
  input  logic [SIZE:1] instr,
  input  logic          wir_so,
  output logic          wir_si,
  output logic          wir_shift,
  output logic          wir_capture,
  output logic          wir_update,
  output logic          WRSTN,
  output logic          busy,
  output logic          done,
  output logic [SIZE:1] prev_instr
);

  localparam int unsigned CW = $clog2(SIZE + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_UPDATE  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]    r_state, w_state_nxt;
  logic [SIZE:1] r_sr, w_sr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [SIZE:1] r_prev_instr;
  logic          r_wir_si, r_wir_shift, r_wir_capture, r_wir_update;
  logic          r_wrstn, r_busy, r_done;
  logic          w_capture_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          w_sr_nxt  = instr;
          w_cnt_nxt = CW'(SIZE - 1);
`ifdef WIR_CAPTURE_EN
          w_state_nxt = ST_CAPTURE;
`else
          w_state_nxt = ST_SHIFT;
`endif
        end
      end
      ST_CAPTURE: begin
        w_state_nxt = abort ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          // old WIR contents enter at the top while the opcode leaves at the bottom
          w_sr_nxt = {wir_so, r_sr[SIZE:2]};
          if (r_cnt == '0) begin
            w_state_nxt = ST_UPDATE;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
      end
      ST_UPDATE: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef WIR_CAPTURE_EN
  assign w_capture_nxt = (w_state_nxt == ST_CAPTURE);
`else
  assign w_capture_nxt = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_sr          <= '0;
      r_cnt         <= '0;
      r_prev_instr  <= '0;
      r_wir_si      <= 1'b0;
      r_wir_shift   <= 1'b0;
      r_wir_capture <= 1'b0;
      r_wir_update  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_wrstn       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sr          <= w_sr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_wir_si      <= (w_state_nxt == ST_SHIFT) ? w_sr_nxt[1] : 1'b0;
      r_wir_shift   <= (w_state_nxt == ST_SHIFT);
      r_wir_capture <= w_capture_nxt;
      r_wir_update  <= (w_state_nxt == ST_UPDATE);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_done        <= (w_state_nxt == ST_DONE);
      r_wrstn       <= 1'b1;
      // sr is stable through UPDATE, so it holds the complete readback here
      if (w_state_nxt == ST_DONE) begin
        r_prev_instr <= r_sr;
      end
    end
  end

  assign wir_si      = r_wir_si;
  assign wir_shift   = r_wir_shift;
  assign wir_capture = r_wir_capture;
  assign wir_update  = r_wir_update;
  assign WRSTN       = r_wrstn;
  assign busy        = r_busy;
  assign done        = r_done;
  assign prev_instr  = r_prev_instr;

endmodule

// File: tb/tb_wir_shift_sequencer.sv
module tb_wir_shift_sequencer;

  localparam int SIZE = 12;
`ifdef WIR_CAPTURE_EN
  localparam int CAP = 1;
`else
  localparam int CAP = 0;
`endif
  localparam logic [SIZE:1] CAP_VAL = 12'hA5C;

  logic          CLK = 1'b0;
  logic          resetn, start, abort, wir_so;
  logic [SIZE:1] instr;
  logic          wir_si, wir_shift, wir_capture, wir_update, WRSTN, busy, done;
  logic [SIZE:1] prev_instr;

  wir_shift_sequencer #(.SIZE(SIZE)) dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .instr      (instr),
    .wir_so     (wir_so),
    .wir_si     (wir_si),
    .wir_shift  (wir_shift),
    .wir_capture(wir_capture),
    .wir_update (wir_update),
    .WRSTN      (WRSTN),
    .busy       (busy),
    .done       (done),
    .prev_instr (prev_instr)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Simple WIR: shift register with capture, update register and async-free reset
  logic [SIZE:1] wir_q = '0;
  logic [SIZE:1] wir_upd_q = '0;
  always @(posedge CLK) begin
    if (!WRSTN) wir_q <= '0;
    else if (wir_capture) wir_q <= CAP_VAL;
    else if (wir_shift) wir_q <= {wir_si, wir_q[SIZE:2]};
    if (WRSTN && wir_update) wir_upd_q <= wir_q;
  end
  assign wir_so = wir_q[1];

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  typedef struct {
    logic [SIZE:1] instr;
    logic [SIZE:1] prev;
    int            k;
  } exp_t;
  exp_t q[$];

  // Reference model: what the WIR holds and what prev_instr should read
  logic [SIZE:1] mdl_wir = '0;
  logic [SIZE:1] model_prev = '0;

  // Monitor / scoreboard
  bit            mon_en = 1'b0;
  int            sh_cnt = 0, cap_cnt = 0, first_sh = -1;
  logic [SIZE:1] bits = '0;
  bit            prev_upd = 1'b0, prev_done = 1'b0;

  always @(negedge CLK) begin
    exp_t e;
    if (mon_en) begin
      chk("strobe_mutex", 64'($countones({wir_capture, wir_shift, wir_update}) <= 1), 64'd1);
      if (done) chk("done_after_update", 64'(prev_upd), 64'd1);
      if (prev_done) chk("idle_after_done", 64'(busy), 64'd0);
      if (wir_capture || wir_shift || wir_update || done) chk("busy_when_active", 64'(busy), 64'd1);
      if (!busy) chk("idle_outputs", 64'({wir_si, wir_capture, wir_shift, wir_update, done}), 64'd0);
      if (wir_capture) cap_cnt++;
      if (wir_shift) begin
        if (sh_cnt == 0) first_sh = cyc;
        if (sh_cnt < SIZE) bits[sh_cnt + 1] = wir_si;
        sh_cnt++;
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("shifted_bits", 64'(bits), 64'(e.instr));
          chk("shift_count", 64'(sh_cnt), 64'(SIZE));
          chk("capture_count", 64'(cap_cnt), 64'(CAP));
          chk("first_shift_cycle", 64'(first_sh), 64'(e.k + CAP));
          chk("done_cycle", 64'(cyc), 64'(e.k + CAP + SIZE + 1));
          chk("prev_instr", 64'(prev_instr), 64'(e.prev));
          chk("wir_update_reg", 64'(wir_upd_q), 64'(e.instr));
        end
      end
      if (!busy || done) begin
        sh_cnt  = 0;
        cap_cnt = 0;
        bits    = '0;
      end
      prev_upd  = wir_update;
      prev_done = done;
    end
  end

  // mode 0: complete load, 1: abort in shift cycle j (j=0: capture cycle), 2: reset in shift j
  task automatic do_load(input logic [SIZE:1] v, input int mode, input int j, input bit hold);
    int k, stop_m;
    logic [SIZE:1] base;
    exp_t e;
    @(negedge CLK);
    start = 1'b1;
    abort = 1'b0;
    instr = v;
    k = cyc + 1;
    base = (CAP != 0) ? CAP_VAL : mdl_wir;
    if (mode == 0) begin
      e.instr = v;
      e.prev  = base;
      e.k     = k;
      q.push_back(e);
      model_prev = base;
      mdl_wir = v;
    end
    stop_m = (j == 0) ? k : k + CAP + j - 1;
    for (int t = 0; t <= CAP + SIZE + 1; t++) begin
      @(negedge CLK);
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      instr = SIZE'($urandom);
      abort = 1'b0;
      // abort during UPDATE/DONE must not stop the load
      if (mode == 0 && !hold && cyc >= k + CAP + SIZE) abort = 1'($urandom_range(0, 1));
      if (mode != 0 && cyc == stop_m) begin
        if (mode == 1) begin
          abort = 1'b1;
          @(negedge CLK);
          chk("abort_busy", 64'(busy), 64'd0);
          chk("abort_prev_instr", 64'(prev_instr), 64'(model_prev));
          mdl_wir = (base >> j) | (v << (SIZE - j));
          abort = 1'b0;
          start = 1'b0;
        end else begin
          resetn = 1'b0;
          @(negedge CLK);
          chk("midreset_outputs",
              64'({wir_si, wir_shift, wir_capture, wir_update, busy, done}), 64'd0);
          chk("midreset_prev", 64'(prev_instr), 64'd0);
          chk("midreset_wrstn", 64'(WRSTN), 64'd0);
          resetn = 1'b1;
          start = 1'b0;
          mdl_wir = '0;
          model_prev = '0;
          @(negedge CLK);
          chk("wrstn_release", 64'(WRSTN), 64'd1);
        end
        return;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      instr = SIZE'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        // start together with abort in IDLE must be dropped
        start = 1'b1;
        abort = 1'b1;
        @(negedge CLK);
        chk("start_abort_idle", 64'(busy), 64'd0);
      end
      start = 1'b0;
      abort = 1'b0;
    end
  endtask

  initial begin
    int mode, j;
    resetn = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    instr  = '0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", 64'({wir_si, wir_shift, wir_capture, wir_update, busy, done}), 64'd0);
    chk("reset_prev", 64'(prev_instr), 64'd0);
    chk("reset_wrstn", 64'(WRSTN), 64'd0);
    resetn = 1'b1;
    @(negedge CLK);
    chk("wrstn_high", 64'(WRSTN), 64'd1);
    mon_en = 1'b1;

    do_load(12'b010010010010, 0, 0, 1'b0);
    idle_cycles(1);
    do_load(12'h001, 0, 0, 1'b1);
    do_load(12'hFFF, 0, 0, 1'b0);
    idle_cycles(2);
    do_load(SIZE'($urandom), 1, 5, 1'b0);
    idle_cycles(1);
    do_load(SIZE'($urandom), 0, 0, 1'b0);
    do_load(SIZE'($urandom), 2, 5, 1'b0);
    idle_cycles(1);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 9);
      if (mode >= 3) mode = 0;
      else if (mode == 2) mode = 2;
      else mode = 1;
      j = (mode == 1 && CAP != 0) ? $urandom_range(0, SIZE) : $urandom_range(1, SIZE);
      do_load(SIZE'($urandom), mode, j, $urandom_range(0, 3) == 0 && mode == 0);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(3);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/wir_shift_sequencer.md
WIR_SHIFT_SEQUENCER -- requirements
Module: wir_shift_sequencer

Interface
REQ-001 Parameter SIZE, default 12: instruction width in bits, equal to the WIR length.
REQ-002 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
REQ-004 start  input  1  request to load a new instruction; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an in-progress load.
REQ-006 instr  input  [SIZE:1]  instruction opcode; captured on the accepted start.
REQ-007 wir_so  input  1  WIR serial output, used for readback.
REQ-008 wir_si  output  1  serial data into the WIR.
REQ-009 wir_shift, wir_capture, wir_update  output  1 each  WIR control strobes.
REQ-010 WRSTN  output  1  WIR reset, active-low.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when a load completes.
REQ-013 prev_instr  output  [SIZE:1]  WIR contents shifted out during the last completed load.

Function
REQ-014 FSM states SHALL be IDLE, CAPTURE, SHIFT, UPDATE and DONE; all outputs SHALL be registered.
REQ-015 In IDLE with start=1, the block SHALL latch instr into shift register sr[SIZE:1] and load a bit counter with SIZE-1.
- Next state: CAPTURE when WIR_CAPTURE_EN is defined, otherwise SHIFT.
REQ-016 CAPTURE SHALL last exactly one cycle with wir_capture=1, then go to SHIFT.
REQ-017 SHIFT SHALL last exactly SIZE cycles with wir_shift=1 and wir_si=sr[1].
- Each edge: sr shifts right by one, sr[SIZE] takes wir_so, counter decrements.
- On counter==0: go to UPDATE.
- Bit order: instr[1] is presented first, instr[SIZE] last.
REQ-018 UPDATE SHALL last one cycle with wir_update=1 and wir_shift=0, then go to DONE.
REQ-019 DONE SHALL last one cycle with done=1 and prev_instr loaded from sr, then go to IDLE.
REQ-020 Latency: let start be sampled at edge k.
- With WIR_CAPTURE_EN: wir_capture high in cycle k+1, wir_shift in k+2..k+SIZE+1, wir_update in k+SIZE+2, done in k+SIZE+3.
- Without WIR_CAPTURE_EN: every strobe moves one cycle earlier.
REQ-021 At most one of wir_capture, wir_shift and wir_update SHALL be high in any cycle.
REQ-022 start while busy=1 SHALL be ignored and SHALL NOT be queued; instr changes while busy SHALL NOT affect the load in progress.
REQ-023 abort=1 in CAPTURE or SHIFT SHALL return to IDLE at the next edge.
- No wir_update, no done, prev_instr unchanged.
REQ-024 abort in UPDATE or DONE SHALL be ignored; the load completes.
REQ-025 abort and start together in IDLE: abort wins and start is dropped.
REQ-026 In IDLE, wir_si SHALL be 0 and all strobes SHALL be 0.
REQ-027 Back-to-back: start high in the DONE cycle SHALL be ignored; start high in the following IDLE cycle SHALL be accepted.

Reset
REQ-028 While resetn=0 at an edge, the next state SHALL be IDLE.
- Reset values: wir_si=0, wir_shift=0, wir_capture=0, wir_update=0, busy=0, done=0, sr=0, counter=0, prev_instr=0.
REQ-029 WRSTN SHALL be 0 in the cycle after any edge with resetn=0, and 1 otherwise.
REQ-030 Reset mid-load SHALL take precedence over all other inputs; no update pulse SHALL be issued.

Configuration
REQ-031 Macro WIR_CAPTURE_EN: when defined, the CAPTURE state exists and prev_instr reflects the captured WIR contents.
- When undefined: CAPTURE is never entered, wir_capture is tied to 0, and prev_instr returns the previous WIR contents shifted out.

Verification
REQ-032 Reset, then start with instr=12'b010010010010, no macro:
- wir_si sequence 0,1,0,0,1,0,0,1,0,0,1,0 over 12 wir_shift cycles.
- wir_update one cycle later, then done.
REQ-033 With WIR_CAPTURE_EN, WIR model capturing 12'hA5C: after the load, prev_instr=12'hA5C and wir_capture was high for exactly 1 cycle before the first shift.
REQ-034 abort during the 5th SHIFT cycle:
- busy=0 at the next edge.
- wir_update and done never asserted.
- prev_instr unchanged.
REQ-035 start held high continuously with instr=12'h001 then 12'hFFF:
- Two loads, separated by exactly one IDLE cycle.
- The second load shifts 12'hFFF.
REQ-036 resetn=0 during SHIFT:
- Next cycle: all outputs at reset values and WRSTN=0.
- No wir_update observed.
REQ-037 Assertion over all tests: mutual exclusion of the three WIR strobes, and done high only in the cycle after wir_update.
